// File: rtl/drum_step_sequencer.sv
// -----------------------------------------------------------------------------
// drum_step_sequencer
//
// Sixteen-step, four-track drum pattern sequencer. A tempo divider advances the
// step index; each new step emits a one-cycle voice_go pulse carrying that
// step's pattern bits. An independent sample divider emits sample_en to advance
// the voice sample counters. hold pauses playback without losing position.
//
// Optional feature: define SEQ_SWING_EN to build swing timing (even steps
// lengthened by tempo/4, odd steps shortened by the same amount). Without the
// macro the swing input is ignored and no swing logic is built.
//
// Ports
//   clk         : clock, all state changes on rising edge
//   reset       : asynchronous active-high reset (clears pattern memory too)
//   start       : one-cycle (re)start request, begins at step 0
//   stop        : one-cycle stop request, wins over start
//   hold        : level, pauses a running sequence while high
//   tempo_div   : clocks per step (0 behaves as 1)
//   sample_div  : clocks per sample tick (0 behaves as 1)
//   pat_we      : pattern write enable
//   pat_addr    : pattern step address
//   pat_data    : pattern data, bit t = track t hit
//   swing       : swing request (only with SEQ_SWING_EN)
//   voice_go    : one-cycle per-track restart pulse
//   sample_en   : one-cycle sample-advance enable
//   step        : current step index
//   playing     : high while running or paused
//   beat        : one-cycle pulse when step 0/4/8/12 begins
// -----------------------------------------------------------------------------
module drum_step_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        hold,
    input  logic [23:0] tempo_div,
    input  logic [11:0] sample_div,
    input  logic        pat_we,
    input  logic [3:0]  pat_addr,
    input  logic [3:0]  pat_data,
    input  logic        swing,
    output logic [3:0]  voice_go,
    output logic        sample_en,
    output logic [3:0]  step,
    output logic        playing,
    output logic        beat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [24:0] tempo_cnt_reg;
    logic [11:0] sample_cnt_reg;
    logic [3:0]  step_reg;
    logic [3:0]  voice_go_reg;
    logic        sample_en_reg;
    logic        beat_reg;
    logic [3:0]  pattern_reg [16];

    // Zero divisors behave as one.
    logic [23:0] tempo_eff;
    logic [11:0] sample_eff;
    logic [24:0] step_len;
    assign tempo_eff  = (tempo_div == 24'd0)  ? 24'd1 : tempo_div;
    assign sample_eff = (sample_div == 12'd0) ? 12'd1 : sample_div;

`ifdef SEQ_SWING_EN
    // Long/short step pairs keep the pair length at 2*tempo, so bar length
    // is unchanged by swing.
    logic [24:0] tempo_quarter;
    assign tempo_quarter = {3'b000, tempo_eff[23:2]};
    assign step_len = !swing       ? {1'b0, tempo_eff} :
                      step_reg[0]  ? {1'b0, tempo_eff} - tempo_quarter :
                                     {1'b0, tempo_eff} + tempo_quarter;
`else
    logic unused_swing;
    assign unused_swing = swing;
    assign step_len     = {1'b0, tempo_eff};
`endif

    // Compare with >= so a divisor shrunk below the running count wraps on
    // the very next clock instead of counting all the way round.
    logic tempo_wrap, sample_wrap, advance;
    logic [3:0] step_inc;
    assign tempo_wrap  = tempo_cnt_reg >= (step_len - 25'd1);
    assign sample_wrap = sample_cnt_reg >= (sample_eff - 12'd1);
    assign step_inc    = step_reg + 4'd1;
    // Counters move on every non-idle clock where hold is low, so a pause
    // freezes exactly the held clocks and resume loses nothing.
    assign advance     = (state_reg != IDLE) && !hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = RUN;
        end else begin
            case (state_reg)
                RUN:     if (hold)  state_next = PAUSE;
                PAUSE:   if (!hold) state_next = RUN;
                default: state_next = state_reg;
            endcase
        end
    end

    // Pattern memory: one flop row per step, cleared by reset.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pat
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pattern_reg[gi] <= 4'd0;
                end else if (pat_we && (pat_addr == 4'(gi))) begin
                    pattern_reg[gi] <= pat_data;
                end
            end
        end
    endgenerate

    // Step/counter datapath. Pattern reads see pre-edge contents, so a step
    // firing on the same edge as a write to its row outputs the old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tempo_cnt_reg  <= 25'd0;
            sample_cnt_reg <= 12'd0;
            step_reg       <= 4'd0;
            voice_go_reg   <= 4'd0;
            sample_en_reg  <= 1'b0;
            beat_reg       <= 1'b0;
        end else begin
            voice_go_reg  <= 4'd0;
            sample_en_reg <= 1'b0;
            beat_reg      <= 1'b0;
            if (stop) begin
                tempo_cnt_reg  <= 25'd0;
                sample_cnt_reg <= 12'd0;
                step_reg       <= 4'd0;
            end else if (start) begin
                tempo_cnt_reg  <= 25'd0;
                sample_cnt_reg <= 12'd0;
                step_reg       <= 4'd0;
                voice_go_reg   <= pattern_reg[0];
                beat_reg       <= 1'b1;
            end else if (advance) begin
                if (tempo_wrap) begin
                    tempo_cnt_reg <= 25'd0;
                    step_reg      <= step_inc;
                    voice_go_reg  <= pattern_reg[step_inc];
                    beat_reg      <= (step_inc[1:0] == 2'b00);
                end else begin
                    tempo_cnt_reg <= tempo_cnt_reg + 25'd1;
                end
                if (sample_wrap) begin
                    sample_cnt_reg <= 12'd0;
                    sample_en_reg  <= 1'b1;
                end else begin
                    sample_cnt_reg <= sample_cnt_reg + 12'd1;
                end
            end
        end
    end

    assign voice_go  = voice_go_reg;
    assign sample_en = sample_en_reg;
    assign step      = step_reg;
    assign beat      = beat_reg;
    assign playing   = (state_reg != IDLE);

endmodule
